// File: rtl/read_and_d_loader_pkg.sv
// Shared widths, reserved addresses, symbol and FSM encodings for the
// run-time loadable short-read / D(i) store.
package read_d_pkg;

    localparam int SYM_W  = 2;
    localparam int D_W    = 8;
    localparam int ADDR_W = 8;
    localparam int WORD_W = SYM_W + D_W;

    // Address 8'hff stands for index -1 and is never written.
    localparam logic [ADDR_W-1:0] ADDR_NEG1 = 8'hff;
    localparam logic [ADDR_W-1:0] MAX_LEN   = 8'd255;

    localparam logic [SYM_W-1:0] SYM_A = 2'b00;
    localparam logic [SYM_W-1:0] SYM_C = 2'b01;
    localparam logic [SYM_W-1:0] SYM_G = 2'b10;
    localparam logic [SYM_W-1:0] SYM_T = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Store word layout: symbol in the top bits, D(i) in the low byte.
    function automatic logic [WORD_W-1:0] pack_word(input logic [SYM_W-1:0] sym,
                                                    input logic [D_W-1:0] d);
        return {sym, d};
    endfunction

endpackage

// File: rtl/read_and_d_loader_if.sv
// Load stream (valid/ready) and combinational read port of the loader.
interface read_and_d_loader_if;
    import read_d_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [SYM_W-1:0]  in_sym;
    logic [D_W-1:0]    in_d;
    logic              in_last;

    logic              ce;
    logic [ADDR_W-1:0] addr;
    logic [D_W-1:0]    d_i;
    logic [SYM_W-1:0]  read_i;

    // Producer of beats and consumer of the read port.
    modport master (
        output in_valid, in_sym, in_d, in_last, ce, addr,
        input  in_ready, d_i, read_i
    );

    // The loader itself.
    modport slave (
        input  in_valid, in_sym, in_d, in_last, ce, addr,
        output in_ready, d_i, read_i
    );
endinterface

// File: rtl/read_and_d_loader_ram.sv
// 256 x 10 store: synchronous write, asynchronous read. Contents survive reset.
module read_d_ram
    import read_d_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [0:(1<<ADDR_W)-1];

    // Write the accepted beat at the accepting edge.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/read_and_d_loader.sv
// Streams a short read into the D(i) store and serves the gated read port
// used by the backward-search core once a load has completed.
module read_and_d_loader
    import read_d_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              loading,
    output logic              done,
    output logic [ADDR_W-1:0] len,
    output logic              ovf,
    read_and_d_loader_if.slave bus
);

    state_t            state_reg;
    logic [ADDR_W-1:0] wr_cnt_reg;
    logic [ADDR_W-1:0] len_reg;
    logic              ovf_reg;
    logic              in_ready_reg;
    logic              loading_reg;
    logic              done_reg;

    logic              accept;
    logic              room;
    logic              we;
    logic [WORD_W-1:0] rdata;

    // in_ready is registered and equals "state is LOAD", so accept needs no decode.
    assign accept = bus.in_valid & in_ready_reg;
    // Slot 255 is the -1 sentinel; the counter parks there once the store is full.
    assign room   = (wr_cnt_reg != MAX_LEN);
    assign we     = accept & room;

    read_d_ram u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (wr_cnt_reg),
        .wdata (pack_word(bus.in_sym, bus.in_d)),
        .raddr (bus.addr),
        .rdata (rdata)
    );

    // Load FSM with counter, length, overflow flag and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            wr_cnt_reg   <= '0;
            len_reg      <= '0;
            ovf_reg      <= 1'b0;
            in_ready_reg <= 1'b0;
            loading_reg  <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_reg    <= ST_LOAD;
                        wr_cnt_reg   <= '0;
                        len_reg      <= '0;
                        ovf_reg      <= 1'b0;
                        in_ready_reg <= 1'b1;
                        loading_reg  <= 1'b1;
                        done_reg     <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (accept) begin
                        if (room) begin
                            wr_cnt_reg <= wr_cnt_reg + 1'b1;
                        end else begin
                            ovf_reg <= 1'b1;
                        end
                        if (bus.in_last) begin
                            len_reg      <= room ? (wr_cnt_reg + 1'b1) : MAX_LEN;
                            state_reg    <= ST_DONE;
                            in_ready_reg <= 1'b0;
                            loading_reg  <= 1'b0;
                            done_reg     <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_reg    <= ST_IDLE;
                    in_ready_reg <= 1'b0;
                    loading_reg  <= 1'b0;
                    done_reg     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready = in_ready_reg;
    assign loading      = loading_reg;
    assign done         = done_reg;
    assign len          = len_reg;
    assign ovf          = ovf_reg;

    // Read port is live only in DONE, with ce set, and never for the -1 address.
    logic port_open;
    assign port_open  = bus.ce & done_reg & (bus.addr != ADDR_NEG1);
    assign bus.d_i    = port_open ? rdata[D_W-1:0] : '0;
    assign bus.read_i = port_open ? rdata[WORD_W-1:D_W] : '0;

endmodule

// File: tb/tb_read_and_d_loader.sv
// Directed bench for read_and_d_loader: basic load, gaps, overflow,
// reset mid-load, reload, read gating and start priority.
module tb_read_and_d_loader;
    import read_d_pkg::*;

    logic       clk;
    logic       rst;
    logic       start;
    logic       loading;
    logic       done;
    logic [7:0] len;
    logic       ovf;

    int checks;
    int failures;

    read_and_d_loader_if bus ();

    read_and_d_loader dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .loading (loading),
        .done    (done),
        .len     (len),
        .ovf     (ovf),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic beat(input logic [1:0] sym, input logic [7:0] d, input logic last);
        bus.in_valid = 1'b1;
        bus.in_sym   = sym;
        bus.in_d     = d;
        bus.in_last  = last;
        tick();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [7:0] a, input logic [1:0] esym, input logic [7:0] ed);
        bus.ce   = 1'b1;
        bus.addr = a;
        #1;
        check({tag, "_sym"}, 32'(bus.read_i), 32'(esym));
        check({tag, "_d"},   32'(bus.d_i),    32'(ed));
        bus.ce = 1'b0;
    endtask

    logic       pat [6];
    logic [1:0] gsym [4];
    logic [7:0] gd [4];

    initial begin
        checks       = 0;
        failures     = 0;
        rst          = 1'b1;
        start        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_sym   = '0;
        bus.in_d     = '0;
        bus.in_last  = 1'b0;
        bus.ce       = 1'b0;
        bus.addr     = '0;
        pat  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        gsym = '{SYM_C, SYM_G, SYM_A, SYM_T};
        gd   = '{8'd10, 8'd20, 8'd30, 8'd40};

        tick();
        tick();
        rst = 1'b0;

        // Reset values
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_loading",  32'(loading), 32'd0);
        check("rst_done",     32'(done), 32'd0);
        check("rst_len",      32'(len), 32'd0);
        check("rst_ovf",      32'(ovf), 32'd0);
        rd("rst_port", 8'd0, 2'b00, 8'd0);

        // Idle beats are ignored
        beat(SYM_T, 8'd99, 1'b1);
        check("idle_beat_done", 32'(done), 32'd0);
        check("idle_beat_len",  32'(len), 32'd0);

        // Test 1: basic load
        pulse_start();
        check("t1_loading",  32'(loading), 32'd1);
        check("t1_in_ready", 32'(bus.in_ready), 32'd1);
        beat(SYM_C, 8'd3, 1'b0);
        beat(SYM_A, 8'd2, 1'b0);
        beat(SYM_T, 8'd2, 1'b0);
        beat(SYM_G, 8'd1, 1'b0);
        check("t1_not_done_yet", 32'(done), 32'd0);
        beat(SYM_A, 8'd0, 1'b1);
        check("t1_done",    32'(done), 32'd1);
        check("t1_loading_off", 32'(loading), 32'd0);
        check("t1_len",     32'(len), 32'd5);
        check("t1_ovf",     32'(ovf), 32'd0);
        rd("t1_a0", 8'd0, 2'b01, 8'd3);
        rd("t1_a2", 8'd2, 2'b11, 8'd2);
        rd("t1_a3", 8'd3, 2'b10, 8'd1);
        rd("t1_a4", 8'd4, 2'b00, 8'd0);
        rd("t1_neg1", 8'hff, 2'b00, 8'd0);

        // Test 6a: ce=0 gates the port in DONE
        bus.ce   = 1'b0;
        bus.addr = 8'd0;
        #1;
        check("t6_ce0_d",   32'(bus.d_i), 32'd0);
        check("t6_ce0_sym", 32'(bus.read_i), 32'd0);

        // Test 5: reload from DONE
        pulse_start();
        check("t5_loading", 32'(loading), 32'd1);
        check("t5_len_clr", 32'(len), 32'd0);
        rd("t5_gated", 8'd0, 2'b00, 8'd0);
        beat(SYM_G, 8'd9, 1'b0);
        beat(SYM_T, 8'd7, 1'b1);
        check("t5_len", 32'(len), 32'd2);
        check("t5_ovf", 32'(ovf), 32'd0);
        rd("t5_a0", 8'd0, 2'b10, 8'd9);
        rd("t5_a1", 8'd1, 2'b11, 8'd7);
        rd("t5_stale2", 8'd2, 2'b11, 8'd2);

        // Test 2: gaps in in_valid
        pulse_start();
        begin
            int k;
            k = 0;
            for (int i = 0; i < 6; i++) begin
                bus.in_valid = pat[i];
                bus.in_sym   = gsym[k];
                bus.in_d     = gd[k];
                bus.in_last  = pat[i] && (k == 3);
                tick();
                if (pat[i]) k++;
            end
            bus.in_valid = 1'b0;
            bus.in_last  = 1'b0;
        end
        check("t2_done", 32'(done), 32'd1);
        check("t2_len",  32'(len), 32'd4);
        rd("t2_a0", 8'd0, SYM_C, 8'd10);
        rd("t2_a1", 8'd1, SYM_G, 8'd20);
        rd("t2_a2", 8'd2, SYM_A, 8'd30);
        rd("t2_a3", 8'd3, SYM_T, 8'd40);

        // Test 6b: start during LOAD is ignored
        pulse_start();
        beat(SYM_A, 8'd50, 1'b0);
        start = 1'b1;
        beat(SYM_C, 8'd51, 1'b0);
        start = 1'b0;
        check("t6_still_loading", 32'(loading), 32'd1);
        beat(SYM_G, 8'd52, 1'b1);
        check("t6_done", 32'(done), 32'd1);
        check("t6_len",  32'(len), 32'd3);
        rd("t6_a1", 8'd1, SYM_C, 8'd51);
        rd("t6_a2", 8'd2, SYM_G, 8'd52);

        // Test 3: overflow with 258 beats (beat n carries sym=n[1:0], d=n[7:0])
        pulse_start();
        for (int n = 1; n <= 258; n++) begin
            logic [8:0] nv;
            nv = 9'(n);
            beat(nv[1:0], nv[7:0], n == 258);
            if (n == 255) check("t3_ovf_at_255", 32'(ovf), 32'd0);
            if (n == 256) check("t3_ovf_at_256", 32'(ovf), 32'd1);
        end
        check("t3_done", 32'(done), 32'd1);
        check("t3_len",  32'(len), 32'd255);
        check("t3_ovf",  32'(ovf), 32'd1);
        rd("t3_a0",   8'd0,   2'b01, 8'd1);
        rd("t3_a254", 8'd254, 2'b11, 8'd255);
        rd("t3_neg1", 8'hff,  2'b00, 8'd0);

        // Test 4: reset mid-load
        pulse_start();
        beat(SYM_T, 8'd1, 1'b0);
        beat(SYM_T, 8'd2, 1'b0);
        beat(SYM_T, 8'd3, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t4_loading",  32'(loading), 32'd0);
        check("t4_done",     32'(done), 32'd0);
        check("t4_len",      32'(len), 32'd0);
        check("t4_ovf",      32'(ovf), 32'd0);
        check("t4_in_ready", 32'(bus.in_ready), 32'd0);
        rd("t4_a0",   8'd0,   2'b00, 8'd0);
        rd("t4_a200", 8'd200, 2'b00, 8'd0);

        // rst has priority over start in the same cycle
        rst   = 1'b1;
        start = 1'b1;
        tick();
        rst   = 1'b0;
        start = 1'b0;
        check("rst_prio_loading", 32'(loading), 32'd0);
        check("rst_prio_ready",   32'(bus.in_ready), 32'd0);

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
